// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for mem_port_arbiter
package mem_arb_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_e;

  typedef enum logic {
    RD,
    WR
  } dir_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side bundle of mem_port_arbiter
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int cache_num  = 2,
  parameter int addr_width = 32,
  parameter int data_width = 32
) ();

  logic [cache_num-1:0]            rd_req;
  logic [cache_num-1:0]            wr_req;
  logic [cache_num-1:0]            rd_gnt;
  logic [cache_num-1:0]            wr_gnt;
  logic [LEN_W*cache_num-1:0]      rd_len;
  logic [LEN_W*cache_num-1:0]      wr_len;
  logic [addr_width*cache_num-1:0] rd_addr;
  logic [addr_width*cache_num-1:0] wr_addr;
  logic [data_width*cache_num-1:0] wr_data;
  logic [cache_num-1:0]            wr_valid;
  logic [cache_num-1:0]            wr_ready;
  logic [data_width-1:0]           rd_data;
  logic [cache_num-1:0]            rd_valid;
  logic [cache_num-1:0]            rd_ready;
  logic [cache_num-1:0]            rd_done;
  logic [cache_num-1:0]            wr_done;

  logic                            mem_req;
  logic                            mem_gnt;
  logic                            mem_we;
  logic [addr_width-1:0]           mem_addr;
  logic [LEN_W-1:0]                mem_len;
  logic [data_width-1:0]           mem_wdata;
  logic                            mem_wvalid;
  logic                            mem_wready;
  logic [data_width-1:0]           mem_rdata;
  logic                            mem_rvalid;
  logic                            mem_rready;

  // Arbiter side
  modport slave (
    input  rd_req, wr_req, rd_len, wr_len, rd_addr, wr_addr,
    input  wr_data, wr_valid, rd_ready,
    input  mem_gnt, mem_wready, mem_rdata, mem_rvalid,
    output rd_gnt, wr_gnt, wr_ready, rd_data, rd_valid, rd_done, wr_done,
    output mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid, mem_rready
  );

  // Caches plus memory, as seen from the arbiter's environment
  modport master (
    output rd_req, wr_req, rd_len, wr_len, rd_addr, wr_addr,
    output wr_data, wr_valid, rd_ready,
    output mem_gnt, mem_wready, mem_rdata, mem_rvalid,
    input  rd_gnt, wr_gnt, wr_ready, rd_data, rd_valid, rd_done, wr_done,
    input  mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid, mem_rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one requester, searching upward from ptr_i
module rr_arbiter #(
  parameter int width = 2
) (
  input  logic [width-1:0]         req_i,
  input  logic [$clog2(width)-1:0] ptr_i,
  output logic [width-1:0]         gnt_o
);

  localparam int IW = $clog2(width);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < width; k++) begin
      idx = IW'((int'(ptr_i) + k) % width);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one burst memory port among cache_num caches
// MEM_ARB_WR_PRIO_EN: pending writes from any cache win over all reads.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int cache_num  = 2,
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(cache_num);

  state_e                 state_q, state_d;
  dir_e                   dir_q, dir_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [addr_width-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   gnt_q, gnt_d;

  logic [cache_num-1:0]   arb_req, arb_win, owner_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   sel_wr, req_phase, xfer_rd, xfer_wr, beat;
  logic [addr_width-1:0]  sel_addr;
  logic [LEN_W-1:0]       sel_len;

`ifdef MEM_ARB_WR_PRIO_EN
  assign arb_req = (|bus.wr_req) ? bus.wr_req : bus.rd_req;
`else
  assign arb_req = bus.wr_req | bus.rd_req;
`endif

  rr_arbiter #(.width(cache_num)) u_rr (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < cache_num; i++) begin
      if (arb_win[i]) win_idx = IDX_W'(i);
    end
  end

  // The winner's write is taken first; with the write-priority build only writers reach here while any exist
  assign sel_wr   = bus.wr_req[win_idx];
  assign sel_addr = sel_wr ? bus.wr_addr[win_idx*addr_width +: addr_width]
                           : bus.rd_addr[win_idx*addr_width +: addr_width];
  assign sel_len  = sel_wr ? bus.wr_len[win_idx*LEN_W +: LEN_W]
                           : bus.rd_len[win_idx*LEN_W +: LEN_W];

  // First REQ cycle carries the grant pulse; the memory request follows one cycle later
  assign req_phase = (state_q == REQ) && !gnt_q;
  assign xfer_wr   = (state_q == XFER) && (dir_q == WR);
  assign xfer_rd   = (state_q == XFER) && (dir_q == RD);
  assign beat      = xfer_wr ? (bus.mem_wvalid && bus.mem_wready)
                             : (xfer_rd && bus.mem_rvalid && bus.mem_rready);
  assign owner_oh  = {{(cache_num-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_req) begin
          owner_d = win_idx;
          dir_d   = sel_wr ? WR : RD;
          addr_d  = sel_addr;
          len_d   = sel_len;
          gnt_d   = 1'b1;
          state_d = (sel_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (req_phase && bus.mem_gnt) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (owner_q == IDX_W'(cache_num - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= RD;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.rd_gnt   = (gnt_q && dir_q == RD) ? owner_oh : '0;
  assign bus.wr_gnt   = (gnt_q && dir_q == WR) ? owner_oh : '0;
  assign bus.rd_done  = (state_q == DONE && dir_q == RD) ? owner_oh : '0;
  assign bus.wr_done  = (state_q == DONE && dir_q == WR) ? owner_oh : '0;

  assign bus.mem_req  = req_phase;
  assign bus.mem_we   = req_phase && (dir_q == WR);
  assign bus.mem_addr = req_phase ? addr_q : '0;
  assign bus.mem_len  = req_phase ? len_q : '0;

  assign bus.mem_wdata  = xfer_wr ? bus.wr_data[owner_q*data_width +: data_width] : '0;
  assign bus.mem_wvalid = xfer_wr && bus.wr_valid[owner_q];
  assign bus.wr_ready   = (xfer_wr && bus.mem_wready) ? owner_oh : '0;

  assign bus.rd_data    = xfer_rd ? bus.mem_rdata : '0;
  assign bus.rd_valid   = (xfer_rd && bus.mem_rvalid) ? owner_oh : '0;
  assign bus.mem_rready = xfer_rd && bus.rd_ready[owner_q];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.cache_num(2), .addr_width(32), .data_width(32)) bus ();

  mem_port_arbiter #(.cache_num(2), .addr_width(32), .data_width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  rd_req, wr_req;
    logic        mem_gnt, mem_rvalid, mem_wready;
    logic [1:0]  rd_ready, wr_valid;
    logic [31:0] rdata, wdata;
    logic [1:0]  e_rd_gnt, e_wr_gnt;
    logic        e_mem_req, e_we;
    logic [31:0] e_addr;
    logic [15:0] e_len;
    logic [1:0]  e_rd_valid, e_wr_ready;
    logic        e_mem_rready, e_mem_wvalid;
    logic [31:0] e_rd_data, e_wdata;
    logic [1:0]  e_rd_done, e_wr_done;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic serve(input int owner, input bit is_wr, input logic [31:0] e_addr,
                       input int e_len, input bit drop);
    bit         seen;
    int         beats;
    logic [3:0] eg;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = (|bus.rd_gnt) || (|bus.wr_gnt);
    end
    check("gnt_seen", 64'(seen), 64'(1));
    eg = is_wr ? (4'b0100 << owner) : (4'b0001 << owner);
    check("gnt_vec", 64'({bus.wr_gnt, bus.rd_gnt}), 64'(eg));
    if (drop) begin
      if (is_wr) bus.wr_req[owner] = 1'b0;
      else       bus.rd_req[owner] = 1'b0;
    end
    if (e_len == 0) begin
      check("len0_done", 64'({bus.wr_done, bus.rd_done}), 64'(eg));
      check("len0_no_req", 64'(bus.mem_req), 64'(0));
      @(negedge clk);
      check("len0_after", 64'({bus.mem_req, bus.wr_done, bus.rd_done}), 64'(0));
      return;
    end
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.mem_req;
    end
    check("mem_req_seen", 64'(seen), 64'(1));
    check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    check("mem_len", 64'(bus.mem_len), 64'(e_len));
    check("mem_we", 64'(bus.mem_we), 64'(is_wr));
    bus.mem_gnt = 1'b1;
    beats = 0;
    seen  = 1'b0;
    for (int n = 0; n < e_len + 20 && !seen; n++) begin
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      if (|{bus.wr_done, bus.rd_done}) begin
        seen = 1'b1;
        check("done_vec", 64'({bus.wr_done, bus.rd_done}), 64'(eg));
      end else if (is_wr ? (bus.mem_wvalid && bus.mem_wready)
                         : ((|bus.rd_valid) && bus.mem_rready)) begin
        beats++;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
    check("beat_count", 64'(beats), 64'(e_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   seen;
    int   beats;

    bus.rd_req = '0; bus.wr_req = '0; bus.mem_gnt = 1'b0;
    bus.rd_len = {16'd8, 16'd4}; bus.wr_len = {16'd2, 16'd3};
    bus.rd_addr = {32'h300, 32'h100}; bus.wr_addr = {32'h400, 32'h200};
    bus.wr_data = '0; bus.wr_valid = '0; bus.rd_ready = '0;
    bus.mem_wready = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;

    // Read burst: cache 0, addr 0x100, len 4
    v = '0; tbl.push_back(v);
    v = '0; v.rd_req = 2'b01; tbl.push_back(v);
    v = '0; v.e_rd_gnt = 2'b01; tbl.push_back(v);
    v = '0; v.e_mem_req = 1; v.e_addr = 32'h100; v.e_len = 4; tbl.push_back(v);
    v = '0; v.mem_gnt = 1; v.e_mem_req = 1; v.e_addr = 32'h100; v.e_len = 4; tbl.push_back(v);
    v = '0; v.mem_rvalid = 1; v.rd_ready = 2'b01; v.rdata = 32'hD000_0000;
    v.e_rd_valid = 2'b01; v.e_mem_rready = 1; v.e_rd_data = 32'hD000_0000; tbl.push_back(v);
    v = '0; v.rd_ready = 2'b01; v.rdata = 32'hD000_0001;
    v.e_mem_rready = 1; v.e_rd_data = 32'hD000_0001; tbl.push_back(v);
    v = '0; v.mem_rvalid = 1; v.rd_ready = 2'b10; v.rdata = 32'hD000_0001;
    v.e_rd_valid = 2'b01; v.e_rd_data = 32'hD000_0001; tbl.push_back(v);
    for (int k = 1; k < 4; k++) begin
      v = '0; v.mem_rvalid = 1; v.rd_ready = 2'b11; v.rdata = 32'hD000_0000 + k;
      v.e_rd_valid = 2'b01; v.e_mem_rready = 1; v.e_rd_data = 32'hD000_0000 + k; tbl.push_back(v);
    end
    v = '0; v.e_rd_done = 2'b01; tbl.push_back(v);
    v = '0; tbl.push_back(v);
    // Write burst: cache 0, addr 0x200, len 3, mem_wready toggling 1,0,1,0,1
    v = '0; v.wr_req = 2'b01; tbl.push_back(v);
    v = '0; v.e_wr_gnt = 2'b01; tbl.push_back(v);
    v = '0; v.mem_gnt = 1; v.e_mem_req = 1; v.e_we = 1; v.e_addr = 32'h200; v.e_len = 3; tbl.push_back(v);
    for (int k = 0; k < 5; k++) begin
      v = '0; v.wr_valid = 2'b11; v.rdata = 32'h77; v.mem_wready = (k % 2 == 0);
      v.wdata = 32'hE000_0000 + (k + 1) / 2; v.e_wdata = v.wdata;
      v.e_mem_wvalid = 1; v.e_wr_ready = v.mem_wready ? 2'b01 : 2'b00; tbl.push_back(v);
    end
    v = '0; v.e_wr_done = 2'b01; tbl.push_back(v);
    v = '0; tbl.push_back(v);

    repeat (2) @(negedge clk);
    check("reset_ctl", 64'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.wr_ready, bus.rd_done,
                            bus.wr_done, bus.mem_req, bus.mem_we, bus.mem_rready, bus.mem_wvalid}), 64'(0));
    check("reset_data", 64'({bus.rd_data, bus.mem_wdata}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge clk); #1;
      bus.rd_req = v.rd_req; bus.wr_req = v.wr_req; bus.mem_gnt = v.mem_gnt;
      bus.mem_rvalid = v.mem_rvalid; bus.mem_wready = v.mem_wready;
      bus.rd_ready = v.rd_ready; bus.wr_valid = v.wr_valid;
      bus.mem_rdata = v.rdata; bus.wr_data = {32'h5555_5555, v.wdata};
      @(negedge clk);
      check($sformatf("r%0d_gnt", i), 64'({bus.wr_gnt, bus.rd_gnt}), 64'({v.e_wr_gnt, v.e_rd_gnt}));
      check($sformatf("r%0d_req", i), 64'({bus.mem_req, bus.mem_we}), 64'({v.e_mem_req, v.e_we}));
      check($sformatf("r%0d_addr", i), 64'(bus.mem_addr), 64'(v.e_addr));
      check($sformatf("r%0d_len", i), 64'(bus.mem_len), 64'(v.e_len));
      check($sformatf("r%0d_rd_hs", i), 64'({bus.rd_valid, bus.mem_rready}), 64'({v.e_rd_valid, v.e_mem_rready}));
      check($sformatf("r%0d_rd_data", i), 64'(bus.rd_data), 64'(v.e_rd_data));
      check($sformatf("r%0d_wr_hs", i), 64'({bus.wr_ready, bus.mem_wvalid}), 64'({v.e_wr_ready, v.e_mem_wvalid}));
      check($sformatf("r%0d_wdata", i), 64'(bus.mem_wdata), 64'(v.e_wdata));
      check($sformatf("r%0d_done", i), 64'({bus.wr_done, bus.rd_done}), 64'({v.e_wr_done, v.e_rd_done}));
    end

    // Reset mid-burst: cache 1 reads 8 beats, reset after 2
    bus.mem_rvalid = 1'b1; bus.rd_ready = 2'b11; bus.wr_valid = 2'b11; bus.mem_wready = 1'b1;
    bus.mem_rdata = 32'hCAFE_0000;
    @(negedge clk);
    bus.rd_req = 2'b10;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = |bus.rd_gnt;
    end
    check("rst_gnt", 64'({seen, bus.rd_gnt}), 64'(3'b110));
    bus.rd_req = 2'b00;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.mem_req;
    end
    check("rst_mem_req", 64'({seen, bus.mem_len}), 64'({1'b1, 16'd8}));
    bus.mem_gnt = 1'b1;
    beats = 0;
    for (int n = 0; n < 20 && beats < 2; n++) begin
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      if ((|bus.rd_valid) && bus.mem_rready) beats++;
    end
    @(negedge clk);
    check("rst_pre_xfer", 64'({bus.rd_valid, bus.rd_data}), 64'({2'b10, 32'hCAFE_0000}));
    rst = 1'b1;
    #1;
    check("rst_ctl", 64'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.wr_ready, bus.rd_done,
                          bus.wr_done, bus.mem_req, bus.mem_we, bus.mem_rready, bus.mem_wvalid}), 64'(0));
    check("rst_data", 64'({bus.rd_data, bus.mem_wdata}), 64'(0));
    check("rst_mem", 64'({bus.mem_addr, bus.mem_len}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      seen = seen || (|bus.rd_done) || (|bus.wr_done) || bus.mem_req;
    end
    check("rst_no_done", 64'(seen), 64'(0));

    // Continuous reads from both caches alternate, starting from pointer 0
    bus.rd_len = {16'd1, 16'd1};
    bus.rd_req = 2'b11;
    serve(0, 1'b0, 32'h100, 1, 1'b0);
    serve(1, 1'b0, 32'h300, 1, 1'b0);
    serve(0, 1'b0, 32'h100, 1, 1'b0);
    serve(1, 1'b0, 32'h300, 1, 1'b0);
    bus.rd_req = 2'b00;

    // Cache 1 holds read and write: write first, then read
    bus.rd_req = 2'b10; bus.wr_req = 2'b10;
    serve(1, 1'b1, 32'h400, 2, 1'b1);
    serve(1, 1'b0, 32'h300, 1, 1'b1);

    // Zero-length burst: grant and done with no memory request
    bus.rd_len = {16'd1, 16'd0};
    bus.rd_addr = {32'h300, 32'h500};
    bus.rd_req = 2'b01;
    serve(0, 1'b0, 32'h500, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
